// File: rtl/countdown_controller.sv
// Countdown clock sequencer: mm:ss BCD down-counter driven by a 1 Hz tick.
// Ports: clk_50MHz/set_n clock and async reset; clk_1Hz divider input;
//   load_p/start_p/pause_p/clear_p button pulses; preset_mm/preset_ss BCD
//   preset; div_rst_n divider reset; min/sec digits; state; alarm; done_p;
//   err (last load rejected).
module countdown_controller #(
    parameter int ALARM_SECS = 5
) (
    input  logic       clk_50MHz,
    input  logic       set_n,
    input  logic       clk_1Hz,
    input  logic       load_p,
    input  logic       start_p,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic [7:0] preset_mm,
    input  logic [7:0] preset_ss,
    output logic       div_rst_n,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       alarm,
    output logic       done_p,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [7:0] ALARM_INIT = 8'(ALARM_SECS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] preset_q, preset_d;
    logic [7:0]  acnt_q, acnt_d;
    logic        alarm_q, alarm_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        div_q, div_d;
    logic        prev_q;

    logic        tick;
    logic        valid;
    logic [15:0] preset_in;
    logic [15:0] dec;

    assign tick      = clk_1Hz & ~prev_q;
    assign preset_in = {preset_mm, preset_ss};
    assign valid     = (preset_mm[7:4] <= 4'd9) && (preset_mm[3:0] <= 4'd9)
                    && (preset_ss[7:4] <= 4'd5) && (preset_ss[3:0] <= 4'd9);

    // BCD decrement with borrow ripple; never applied to 00:00.
    always_comb begin
        dec = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            dec[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            dec[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                dec[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                dec[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    dec[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    dec[11:8]  = 4'd9;
                    dec[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        acnt_d   = acnt_q;
        alarm_d  = alarm_q;
        done_d   = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (clear_p) begin
                    cnt_d = preset_q;
                    err_d = 1'b0;
                end else if (start_p) begin
                    if (cnt_q != 16'h0000) state_d = RUN;
                end else if (load_p) begin
                    if (valid) begin
                        preset_d = preset_in;
                        cnt_d    = preset_in;
                        err_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (clear_p) begin
                    state_d = IDLE;
                    cnt_d   = preset_q;
                    err_d   = 1'b0;
                end else if (tick && dec == 16'h0000) begin
                    state_d = DONE;
                    cnt_d   = dec;
                    done_d  = 1'b1;
                    alarm_d = (ALARM_INIT != 8'd0);
                    acnt_d  = ALARM_INIT;
                end else begin
                    // a coincident tick still lands before the pause
                    if (tick) cnt_d = dec;
                    if (pause_p) state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d = IDLE;
                    cnt_d   = preset_q;
                    err_d   = 1'b0;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear_p) begin
                    state_d = IDLE;
                    cnt_d   = preset_q;
                    alarm_d = 1'b0;
                    acnt_d  = 8'd0;
                    err_d   = 1'b0;
                end else if (tick && acnt_q != 8'd0) begin
                    acnt_d = acnt_q - 8'd1;
                    if (acnt_q == 8'd1) alarm_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered so the divider leaves reset on the edge that enters RUN.
    assign div_d = (state_d == RUN) || (state_d == DONE);

    always_ff @(posedge clk_50MHz or negedge set_n) begin
        if (!set_n) begin
            state_q  <= IDLE;
            cnt_q    <= 16'h0000;
            preset_q <= 16'h0000;
            acnt_q   <= 8'd0;
            alarm_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            div_q    <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
            acnt_q   <= acnt_d;
            alarm_q  <= alarm_d;
            done_q   <= done_d;
            err_q    <= err_d;
            div_q    <= div_d;
            prev_q   <= clk_1Hz;
        end
    end

    assign div_rst_n = div_q;
    assign min_tens  = cnt_q[15:12];
    assign min_ones  = cnt_q[11:8];
    assign sec_tens  = cnt_q[7:4];
    assign sec_ones  = cnt_q[3:0];
    assign state     = state_q;
    assign alarm     = alarm_q;
    assign done_p    = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Testbench for countdown_controller: table-driven vectors plus reset checks.
// Each vector drives one cycle of inputs, then one idle cycle.
module tb_countdown_controller;

    logic       clk = 1'b0;
    logic       set_n;
    logic       clk_1Hz, load_p, start_p, pause_p, clear_p;
    logic [7:0] preset_mm, preset_ss;
    logic       div_rst_n, alarm, done_p, err;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    countdown_controller #(.ALARM_SECS(3)) dut (
        .clk_50MHz(clk),
        .set_n(set_n),
        .clk_1Hz(clk_1Hz),
        .load_p(load_p),
        .start_p(start_p),
        .pause_p(pause_p),
        .clear_p(clear_p),
        .preset_mm(preset_mm),
        .preset_ss(preset_ss),
        .div_rst_n(div_rst_n),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .state(state),
        .alarm(alarm),
        .done_p(done_p),
        .err(err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        ld, st, pa, cl, tk;
        logic [7:0]  mm, ss;
        logic [15:0] cnt;
        logic [1:0]  stt;
        logic        dv, al, dn, er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic ld, logic st, logic pa, logic cl,
                                logic tk, logic [7:0] mm, logic [7:0] ss,
                                logic [15:0] cnt, logic [1:0] stt,
                                logic dv, logic al, logic dn, logic er);
        vec_t v;
        v.ld = ld; v.st = st; v.pa = pa; v.cl = cl; v.tk = tk;
        v.mm = mm; v.ss = ss; v.cnt = cnt; v.stt = stt;
        v.dv = dv; v.al = al; v.dn = dn; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(int idx, logic [15:0] cnt, logic [1:0] stt,
                           logic dv, logic al, logic dn, logic er);
        chk("count", idx, {min_tens, min_ones, sec_tens, sec_ones}, cnt);
        chk("state", idx, 16'(state), 16'(stt));
        chk("div_rst_n", idx, 16'(div_rst_n), 16'(dv));
        chk("alarm", idx, 16'(alarm), 16'(al));
        chk("done_p", idx, 16'(done_p), 16'(dn));
        chk("err", idx, 16'(err), 16'(er));
    endtask

    task automatic idle_inputs();
        clk_1Hz = 0; load_p = 0; start_p = 0; pause_p = 0; clear_p = 0;
    endtask

    localparam logic [1:0] I = 2'b00, R = 2'b01, P = 2'b10, D = 2'b11;

    initial begin
        //  ld st pa cl tk  mm     ss     count    st dv al dn er
        add(1, 0, 0, 0, 0, 8'h12, 8'h34, 16'h1234, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h12, 8'h60, 16'h1234, I, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 8'h10, 8'h00, 16'h1000, I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h1000, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0959, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0958, R, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h00, 16'h1000, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h02, 16'h0002, I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0002, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0001, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, D, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, D, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 8'h00, 8'h00, 16'h0000, D, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, D, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, D, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, D, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000, D, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 8'h00, 8'h00, 16'h0002, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h05, 16'h0005, I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0005, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0004, R, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 16'h0004, P, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0004, P, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0004, P, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0004, P, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0004, R, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0003, R, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h00, 16'h0002, P, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0002, R, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 8'h00, 8'h00, 16'h0005, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h1A, 8'h00, 16'h0005, I, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 8'h00, 8'h00, 16'h0005, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000, I, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8'h05, 8'h17, 16'h0517, I, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0517, R, 1, 0, 0, 0);

        idle_inputs();
        preset_mm = 8'h00;
        preset_ss = 8'h00;
        set_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 16'h0000, I, 0, 0, 0, 0);
        @(negedge clk);
        set_n = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            load_p = vecs[i].ld;
            start_p = vecs[i].st;
            pause_p = vecs[i].pa;
            clear_p = vecs[i].cl;
            clk_1Hz = vecs[i].tk;
            preset_mm = vecs[i].mm;
            preset_ss = vecs[i].ss;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].cnt, vecs[i].stt, vecs[i].dv,
                    vecs[i].al, vecs[i].dn, vecs[i].er);
            @(negedge clk);
            idle_inputs();
            @(posedge clk);
        end

        // Async reset mid-RUN at 05:17, sampled before any clock edge.
        @(negedge clk);
        #3;
        set_n = 0;
        #1;
        chk_all(100, 16'h0000, I, 0, 0, 0, 0);
        @(negedge clk);
        set_n = 1;

        // Preset is lost: clear in IDLE reloads 00:00.
        clear_p = 1;
        @(posedge clk);
        #1;
        chk_all(101, 16'h0000, I, 0, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_controller.md
# countdown_controller

Sequencing controller for the countdown clock. It consumes the 1 Hz square wave from the clock divider and gates the divider through its active-low reset. It holds an mm:ss BCD count, decrements it once per second while running, and raises an alarm on expiry. It sits between the debounced button logic and the seven-segment digit drivers.

## Interface
- ALARM_SECS, 5, number of 1 Hz ticks the alarm stays high after expiry (0..255; 0 disables the alarm)
- clk_50MHz  input  1  system clock; all logic on the rising edge
- set_n  input  1  asynchronous active-low reset
- clk_1Hz  input  1  1 Hz square wave from the divider, synchronous to clk_50MHz
- load_p  input  1  one-cycle pulse: latch the preset
- start_p  input  1  one-cycle pulse: start or resume
- pause_p  input  1  one-cycle pulse: pause
- clear_p  input  1  one-cycle pulse: abort and reload the preset
- preset_mm  input  8  BCD minutes {tens, ones}
- preset_ss  input  8  BCD seconds {tens, ones}
- div_rst_n  output  1  registered active-low reset to the divider
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  current count in BCD
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- alarm  output  1  alarm level
- done_p  output  1  one-cycle pulse when the count reaches 00:00
- err  output  1  sticky flag: last load was rejected

## Operation
- Tick detect: a register samples clk_1Hz. tick = clk_1Hz & ~prev, so it is high for one cycle after each rising edge.
- Preset register (16 bits) holds the last valid preset.
- A preset is valid when every digit is ≤ 9 and the seconds tens digit is ≤ 5.
- Event priority within a cycle: clear_p > start_p > pause_p > tick. load_p is honoured only in IDLE.
- IDLE:
  - load_p with a valid preset: preset register and count ← preset, err ← 0.
  - load_p with an invalid preset: no change except err ← 1.
  - start_p with count ≠ 00:00 → RUN. With count = 00:00, start_p is ignored.
- RUN:
  - tick decrements the count in BCD.
  - Seconds ones 0 → 9 with a borrow from seconds tens.
  - Seconds 00 → 59 with a borrow from minutes. Minutes borrow works the same way, ones 0 → 9 and borrow tens.
  - A decrement that reaches 00:00 → DONE in the same cycle, done_p = 1, alarm ← 1 (if ALARM_SECS ≠ 0), alarm counter ← ALARM_SECS.
  - pause_p → PAUSE. If tick occurs in the same cycle, the decrement is applied first, then the state moves to PAUSE.
  - clear_p → IDLE, count ← preset register, and no decrement that cycle.
- PAUSE:
  - Count is frozen and ticks are ignored.
  - start_p → RUN.
  - clear_p → IDLE with reload.
- DONE:
  - Count holds 00:00.
  - Each tick decrements the alarm counter; alarm drops when the counter reaches 0, and the state stays DONE.
  - start_p and pause_p are ignored.
  - clear_p → IDLE with reload and alarm ← 0.
- div_rst_n = 1 in RUN and DONE, 0 in IDLE and PAUSE.
  - The divider restarts from its reset phase on every start and resume, so the first second after a start is a full second.
  - The divider holds clk_1Hz low during reset, so no false edge appears on release.
- err is cleared by a valid load or by clear_p.

## Timing
- Reset (set_n low, asynchronous):
  - state = IDLE, all digits = 0, preset register = 00:00.
  - div_rst_n = 0, alarm = 0, done_p = 0, err = 0, tick sample register = 0.
- All outputs are registered.
- Transitions take effect on the clock edge after the input pulse.
- div_rst_n rises on the same edge at which state becomes RUN.
- Tick latency: clk_1Hz rising in cycle n → tick in cycle n → count updated at the edge ending cycle n, visible in n+1.
- done_p and alarm assert in the same cycle the digits show 00:00.
- Reset mid-RUN or mid-DONE forces the full reset state immediately; the preset is lost.
- Back-to-back ticks cannot occur: the detector fires once per rising edge.

## Test plan
- Load and validate:
  - load_p with mm = 0x12, ss = 0x34 → digits 1,2,3,4, err = 0.
  - load_p with ss = 0x60 → digits unchanged, err = 1.
  - A following valid load → err = 0.
- Borrow chain: preset 10:00, start, one tick → 09:59. Next tick → 09:58. state = RUN throughout and div_rst_n = 1 after start.
- Expiry and alarm with ALARM_SECS = 3:
  - preset 00:02, start, two ticks → 00:00, state = DONE, done_p high for exactly one cycle, alarm = 1.
  - Three more ticks → alarm = 0 and state stays DONE.
- Pause/resume:
  - preset 00:05, start, 1 tick (00:04), pause_p → state = PAUSE, div_rst_n = 0.
  - 3 edges on clk_1Hz → still 00:04.
  - start_p → RUN, div_rst_n = 1.
- Simultaneous events:
  - pause_p coincident with tick at 00:03 → 00:02 and PAUSE.
  - clear_p coincident with tick in RUN → IDLE, count = preset, no decrement.
  - start_p in IDLE at 00:00 → stays IDLE.
- Async reset: assert set_n mid-RUN at 05:17 → all digits 0, state = IDLE, div_rst_n = 0, alarm = 0 with no clock edge.
